// File: rtl/buf_feeder_if.sv
// Downstream word stream for buf_feeder: data plus valid/ready handshake and
// a last marker qualifying the final word of each pass.
interface buf_feeder_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/buf_feeder.sv
// Read-side sequencer for the obli buffer: sweeps addresses n_pass times and
// streams words through a 2-entry skid FIFO. Optional macro: BUF_FEEDER_ABORT_EN.
module buf_feeder #(
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_nDATA  = 1024,
  parameter  int MAX_PASS   = 256,
  localparam int ADDR_WIDTH = $clog2(MAX_nDATA),
  localparam int PASS_WIDTH = $clog2(MAX_PASS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_data,
  input  logic [PASS_WIDTH-1:0] n_pass,
`ifdef BUF_FEEDER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  buf_re,
  output logic [ADDR_WIDTH-1:0] buf_raddr,
  input  logic [DATA_WIDTH-1:0] buf_data,
  buf_feeder_if.master          m,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_t;

  localparam logic [ADDR_WIDTH:0]   N_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [PASS_WIDTH-1:0] P_ONE = PASS_WIDTH'(1);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [PASS_WIDTH-1:0] pass_r;
  logic [ADDR_WIDTH:0]   n_data_r;
  logic [PASS_WIDTH-1:0] n_pass_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  inflight_r;
  logic                  inflight_last_r;
  logic [DATA_WIDTH-1:0] fifo_data_r [2];
  logic                  fifo_last_r [2];
  logic                  rd_ptr_r;
  logic                  wr_ptr_r;
  logic [1:0]            count_r;

  logic                  abort_s;
  logic                  abort_hit_s;
  logic                  pop_s;
  logic [2:0]            occ_s;
  logic                  buf_re_s;
  logic                  addr_last_s;
  logic                  pass_last_s;
  logic                  drained_s;

`ifdef BUF_FEEDER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign m.valid     = (count_r != 2'd0);
  assign m.data      = fifo_data_r[rd_ptr_r];
  assign m.last      = fifo_last_r[rd_ptr_r] & m.valid;
  assign pop_s       = m.valid & m.ready;
  assign buf_re      = buf_re_s;
  assign buf_raddr   = addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign abort_hit_s = abort_s && ((state_r == ST_RUN) || (state_r == ST_DRAIN));

  // Credit check, sweep-end detection and drain completion from current state.
  always_comb begin
    occ_s       = 3'(count_r) + 3'(inflight_r) - 3'(pop_s);
    addr_last_s = ({1'b0, addr_r} == (n_data_r - N_ONE));
    pass_last_s = (pass_r == (n_pass_r - P_ONE));
    // The popped head leaves this edge, so count==pop means empty afterwards.
    drained_s   = !inflight_r && (count_r == 2'(pop_s));
    if ((state_r == ST_RUN) && !abort_s && (occ_s < 3'd2)) begin
      buf_re_s = 1'b1;
    end else begin
      buf_re_s = 1'b0;
    end
  end

  // Sequencer FSM with address/pass counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      pass_r   <= '0;
      n_data_r <= '0;
      n_pass_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if ((n_data == '0) || (n_pass == '0)) begin
              state_r <= ST_DONE;
            end else begin
              n_data_r <= n_data;
              n_pass_r <= n_pass;
              addr_r   <= '0;
              pass_r   <= '0;
              busy_r   <= 1'b1;
              state_r  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            addr_r  <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (buf_re_s) begin
            if (addr_last_s) begin
              addr_r <= '0;
              pass_r <= pass_r + P_ONE;
              if (pass_last_s) begin
                state_r <= ST_DRAIN;
              end
            end else begin
              addr_r <= addr_r + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (abort_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (drained_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Skid FIFO: captures read data one cycle after the strobe, pops on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      rd_ptr_r        <= 1'b0;
      wr_ptr_r        <= 1'b0;
      count_r         <= 2'd0;
      fifo_data_r[0]  <= '0;
      fifo_data_r[1]  <= '0;
      fifo_last_r[0]  <= 1'b0;
      fifo_last_r[1]  <= 1'b0;
    end else if (abort_hit_s) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      rd_ptr_r        <= 1'b0;
      wr_ptr_r        <= 1'b0;
      count_r         <= 2'd0;
    end else begin
      inflight_r      <= buf_re_s;
      inflight_last_r <= buf_re_s & addr_last_s;
      if (inflight_r) begin
        fifo_data_r[wr_ptr_r] <= buf_data;
        fifo_last_r[wr_ptr_r] <= inflight_last_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_buf_feeder.sv
// Directed self-checking bench for buf_feeder; the buffer model returns
// 16'hA000 + address one cycle after each read strobe.
module tb_buf_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] n_data = 11'd0;
  logic [8:0]  n_pass = 9'd0;
  logic        buf_re;
  logic [9:0]  buf_raddr;
  logic [15:0] buf_data = 16'd0;
  logic        busy;
  logic        done;
`ifdef BUF_FEEDER_ABORT_EN
  logic        abort = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  buf_feeder_if #(.DATA_WIDTH(16)) m ();

  buf_feeder dut (
    .clk(clk), .rst(rst), .start(start), .n_data(n_data), .n_pass(n_pass),
`ifdef BUF_FEEDER_ABORT_EN
    .abort(abort),
`endif
    .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_data(buf_data),
    .m(m.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_re) buf_data <= 16'hA000 + 16'(buf_raddr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    m.ready = 1'b1;
    rst = 1'b1;
    cyc(); cyc(); smp();
    checks += 7;
    if (buf_re !== 1'b0)       begin errors++; $display("FAIL rst_buf_re got %b exp 0", buf_re); end
    if (buf_raddr !== 10'd0)   begin errors++; $display("FAIL rst_raddr got %0d exp 0", buf_raddr); end
    if (m.valid !== 1'b0)      begin errors++; $display("FAIL rst_valid got %b exp 0", m.valid); end
    if (m.last !== 1'b0)       begin errors++; $display("FAIL rst_last got %b exp 0", m.last); end
    if (m.data !== 16'h0000)   begin errors++; $display("FAIL rst_data got %h exp 0000", m.data); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    cyc(); rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_pass();
    logic ev;
    for (int c = 0; c < 11; c++) begin
      cyc();
      start = (c == 0); n_data = 11'd4; n_pass = 9'd1; m.ready = 1'b1;
      smp();
      checks += 4;
      if (buf_re !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL sp_re c=%0d got %b", c, buf_re); end
      if (buf_re && buf_raddr !== 10'(c - 1)) begin errors++; $display("FAIL sp_raddr c=%0d got %0d exp %0d", c, buf_raddr, c - 1); end
      ev = (c >= 3 && c <= 6);
      if (m.valid !== ev) begin errors++; $display("FAIL sp_valid c=%0d got %b exp %b", c, m.valid, ev); end
      if (ev) begin
        checks += 2;
        if (m.data !== 16'hA000 + 16'(c - 3)) begin errors++; $display("FAIL sp_data c=%0d got %h exp %h", c, m.data, 16'hA000 + 16'(c - 3)); end
        if (m.last !== (c == 6)) begin errors++; $display("FAIL sp_last c=%0d got %b exp %b", c, m.last, c == 6); end
      end
      if (done !== (c == 8)) begin errors++; $display("FAIL sp_done c=%0d got %b exp %b", c, done, c == 8); end
      if (busy !== (c >= 1 && c <= 6)) begin errors++; $display("FAIL sp_busy c=%0d got %b", c, busy); end
    end
  endtask

  task automatic test_multi_pass(input logic [10:0] nd, input logic [8:0] np, input string nm);
    int nre = 0;
    int ndone = 0;
    int nw = 0;
    int total = int'(nd) * int'(np);
    logic [15:0] ed;
    for (int c = 0; c < 60 && ndone == 0; c++) begin
      cyc();
      start = (c == 0); n_data = nd; n_pass = np; m.ready = 1'b1;
      smp();
      if (buf_re) begin
        nre++;
        checks++;
        if (buf_raddr !== 10'((nre - 1) % int'(nd))) begin errors++; $display("FAIL %s_raddr got %0d exp %0d", nm, buf_raddr, (nre - 1) % int'(nd)); end
      end
      if (m.valid && m.ready) begin
        ed = 16'hA000 + 16'(nw % int'(nd));
        checks += 2;
        if (m.data !== ed) begin errors++; $display("FAIL %s_data w=%0d got %h exp %h", nm, nw, m.data, ed); end
        if (m.last !== (nw % int'(nd) == int'(nd) - 1)) begin errors++; $display("FAIL %s_last w=%0d got %b", nm, nw, m.last); end
        nw++;
      end
      if (done) ndone++;
    end
    cyc(); smp();
    checks += 4;
    if (ndone != 1) begin errors++; $display("FAIL %s_done got %0d exp 1", nm, ndone); end
    if (nre != total) begin errors++; $display("FAIL %s_nre got %0d exp %0d", nm, nre, total); end
    if (nw != total) begin errors++; $display("FAIL %s_words got %0d exp %0d", nm, nw, total); end
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b exp 0", nm, done); end
  endtask

  task automatic test_backpressure();
    int issued = 0;
    int nw = 0;
    int ndone = 0;
    logic stall = 1'b0;
    logic [15:0] pd = 16'd0;
    logic pl = 1'b0;
    for (int c = 0; c < 80 && ndone == 0; c++) begin
      cyc();
      start = (c == 0); n_data = 11'd8; n_pass = 9'd1;
      m.ready = ((c % 4) == 0) || ((c % 4) == 3);
      smp();
      checks++;
      if (issued - nw > 2) begin errors++; $display("FAIL bp_outstanding c=%0d got %0d exp <=2", c, issued - nw); end
      if (stall) begin
        checks += 3;
        if (m.valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c=%0d got %b exp 1", c, m.valid); end
        if (m.data !== pd) begin errors++; $display("FAIL bp_hold_data c=%0d got %h exp %h", c, m.data, pd); end
        if (m.last !== pl) begin errors++; $display("FAIL bp_hold_last c=%0d got %b exp %b", c, m.last, pl); end
      end
      if (buf_re) issued++;
      if (m.valid && m.ready) begin
        checks += 2;
        if (m.data !== 16'hA000 + 16'(nw)) begin errors++; $display("FAIL bp_data w=%0d got %h exp %h", nw, m.data, 16'hA000 + 16'(nw)); end
        if (m.last !== (nw == 7)) begin errors++; $display("FAIL bp_last w=%0d got %b exp %b", nw, m.last, nw == 7); end
        nw++;
      end
      stall = m.valid && !m.ready;
      pd = m.data;
      pl = m.last;
      if (done) ndone++;
    end
    m.ready = 1'b1;
    checks += 3;
    if (nw != 8) begin errors++; $display("FAIL bp_words got %0d exp 8", nw); end
    if (issued != 8) begin errors++; $display("FAIL bp_nre got %0d exp 8", issued); end
    if (ndone != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", ndone); end
  endtask

  task automatic test_degenerate();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 7; c++) begin
        cyc();
        // c==1 retries start while the FSM sits in DONE; it must be ignored.
        start = (c <= 1);
        n_data = (k == 0 && c == 0) ? 11'd0 : 11'd4;
        n_pass = (k == 1 && c == 0) ? 9'd0 : 9'd1;
        m.ready = 1'b1;
        smp();
        checks += 3;
        if (buf_re !== 1'b0) begin errors++; $display("FAIL dg%0d_re c=%0d got %b exp 0", k, c, buf_re); end
        if (done !== (c == 2)) begin errors++; $display("FAIL dg%0d_done c=%0d got %b exp %b", k, c, done, c == 2); end
        if (busy !== 1'b0) begin errors++; $display("FAIL dg%0d_busy c=%0d got %b exp 0", k, c, busy); end
      end
    end
    test_multi_pass(11'd1, 9'd3, "one");
  endtask

  task automatic test_reset_mid_job();
    for (int c = 0; c < 8; c++) begin
      cyc();
      start = (c == 0); n_data = 11'd16; n_pass = 9'd1; m.ready = 1'b1;
      rst = (c == 6);
      smp();
      if (c == 6) begin
        checks += 2;
        if (m.valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b exp 1", m.valid); end
        if (m.data !== 16'hA003) begin errors++; $display("FAIL rm_pre_data got %h exp a003", m.data); end
      end
      if (c == 7) begin
        checks += 3;
        if (m.valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", m.valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
        if (buf_re !== 1'b0) begin errors++; $display("FAIL rm_re got %b exp 0", buf_re); end
      end
    end
    test_multi_pass(11'd5, 9'd1, "rm_restart");
  endtask

`ifdef BUF_FEEDER_ABORT_EN
  task automatic test_abort();
    for (int c = 0; c < 16; c++) begin
      cyc();
      start = (c == 0); n_data = 11'd16; n_pass = 9'd1; m.ready = 1'b1;
      abort = (c == 5);
      smp();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL ab_done c=%0d got %b exp 0", c, done); end
      if (c == 6) begin
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b exp 0", busy); end
        if (m.valid !== 1'b0) begin errors++; $display("FAIL ab_valid got %b exp 0", m.valid); end
        if (buf_re !== 1'b0) begin errors++; $display("FAIL ab_re got %b exp 0", buf_re); end
      end
    end
    cyc();
    start = 1'b1; abort = 1'b1; n_data = 11'd2; n_pass = 9'd1;
    smp();
    cyc();
    start = 1'b0; abort = 1'b0;
    smp();
    checks += 3;
    if (buf_re !== 1'b1) begin errors++; $display("FAIL ab_start_wins_re got %b exp 1", buf_re); end
    if (buf_raddr !== 10'd0) begin errors++; $display("FAIL ab_start_wins_raddr got %0d exp 0", buf_raddr); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ab_start_wins_busy got %b exp 1", busy); end
    for (int c = 0; c < 12; c++) begin cyc(); end
  endtask
`endif

  initial begin
    m.ready = 1'b1;
    test_reset();
    test_single_pass();
    test_multi_pass(11'd3, 9'd2, "mp");
    test_backpressure();
    test_degenerate();
    test_reset_mid_job();
`ifdef BUF_FEEDER_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
